pea_33_ctrl: RTL and testbench

Sequencer for the 3x3 PE array (3 kernel rows x COL output rows), which is the datapath it drives. It walks the oc -> ic -> ifm-column loop nest for one tile. It also:
- generates the weight/ifm register-file read strobes, gated by upstream valid;
- aligns per-row pvalid with the PE pipeline;
- pulses ic_done/oc_done to the partial-sum buffers.

It sits between the tile scheduler (start/cfg/done) and the PE array.

---
 rtl/pea_33_ctrl_pkg.sv | 25 ++
 rtl/pea_33_vld_pipe.sv | 34 +++
 rtl/pea_33_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pea_33_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_33_ctrl_pkg.sv
// Shared types and constants for the 3x3 PE-array sequencer.
package pea_33_ctrl_pkg;

    localparam int unsigned KERNEL_K  = 3;
    localparam int unsigned PE_LAT    = 2;
    localparam int unsigned CFG_CNT_W = 8;
    localparam int unsigned CFG_ROW_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WGT,
        ST_IFM,
        ST_DRAIN,
        ST_DONE
    } pea_state_e;

    typedef struct packed {
        logic                 stride;
        logic [CFG_CNT_W-1:0] ic_num;
        logic [CFG_CNT_W-1:0] oc_num;
        logic [CFG_CNT_W-1:0] ifm_w;
        logic [CFG_ROW_W-1:0] row_vld;
    } pea_cfg_t;

endpackage

// File: rtl/pea_33_vld_pipe.sv
// Fixed-latency delay line carrying the {emit, last_ic, last_oc} tag alongside the PE pipeline.
module pea_33_vld_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] tag_in,
    output logic [W-1:0] tag_out
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/pea_33_ctrl.sv
// oc -> ic -> ifm-column sequencer for the 3x3 PE array.
// Optional stall counter output enabled by defining PEA_33_CTRL_PERF_EN.
module pea_33_ctrl #(
    parameter int unsigned COL    = 8,
    parameter int unsigned PE_LAT = pea_33_ctrl_pkg::PE_LAT,
    parameter int unsigned CNT_W  = pea_33_ctrl_pkg::CFG_CNT_W,
    localparam int unsigned ROW_W = $clog2(COL) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             cfg_stride,
    input  logic [CNT_W-1:0] cfg_ic_num,
    input  logic [CNT_W-1:0] cfg_oc_num,
    input  logic [CNT_W-1:0] cfg_ifm_w,
    input  logic [ROW_W-1:0] cfg_row_vld,
    input  logic             wgt_vld,
    input  logic             ifm_vld,
    output logic             busy,
    output logic             done,
    output logic             stride,
    output logic             wgt_read,
    output logic             ifm_read,
    output logic [COL-1:0]   pvalid,
    output logic             ic_done,
    output logic             oc_done
`ifdef PEA_33_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);
    import pea_33_ctrl_pkg::*;

    localparam int unsigned DRN_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    pea_state_e       state_q, state_d;
    pea_cfg_t         cfg_q, cfg_d;
    logic [CNT_W-1:0] oc_cnt_q, oc_cnt_d;
    logic [CNT_W-1:0] ic_cnt_q, ic_cnt_d;
    logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [1:0]       wgt_cnt_q, wgt_cnt_d;
    logic [DRN_W-1:0] drn_cnt_q, drn_cnt_d;

    logic [CNT_W-1:0] ic_num, oc_num, ifm_w, oc_col, last_col;
    logic [ROW_W-1:0] row_vld;
    logic [COL-1:0]   row_mask;
    logic             emit, last_ic, last_oc;
    logic [2:0]       tag_in, tag_out;

    assign ic_num  = CNT_W'(cfg_q.ic_num);
    assign oc_num  = CNT_W'(cfg_q.oc_num);
    assign ifm_w   = CNT_W'(cfg_q.ifm_w);
    assign row_vld = ROW_W'(cfg_q.row_vld);

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        oc_cnt_d  = oc_cnt_q;
        ic_cnt_d  = ic_cnt_q;
        col_cnt_d = col_cnt_q;
        wgt_cnt_d = wgt_cnt_q;
        drn_cnt_d = drn_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_d.stride  = cfg_stride;
                    cfg_d.ic_num  = CFG_CNT_W'(cfg_ic_num);
                    cfg_d.oc_num  = CFG_CNT_W'(cfg_oc_num);
                    cfg_d.ifm_w   = CFG_CNT_W'(cfg_ifm_w);
                    cfg_d.row_vld = CFG_ROW_W'(cfg_row_vld);
                    oc_cnt_d      = '0;
                    ic_cnt_d      = '0;
                    wgt_cnt_d     = '0;
                    state_d       = ST_WGT;
                end
            end
            ST_WGT: begin
                if (wgt_vld) begin
                    if (wgt_cnt_q == 2'(KERNEL_K - 1)) begin
                        wgt_cnt_d = '0;
                        col_cnt_d = '0;
                        state_d   = ST_IFM;
                    end else begin
                        wgt_cnt_d = wgt_cnt_q + 2'd1;
                    end
                end
            end
            ST_IFM: begin
                if (ifm_vld) begin
                    if (col_cnt_q == ifm_w) begin
                        drn_cnt_d = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drn_cnt_q == DRN_W'(PE_LAT - 1)) begin
                    drn_cnt_d = '0;
                    if (ic_cnt_q < ic_num) begin
                        ic_cnt_d = ic_cnt_q + 1'b1;
                        state_d  = ST_WGT;
                    end else if (oc_cnt_q < oc_num) begin
                        ic_cnt_d = '0;
                        oc_cnt_d = oc_cnt_q + 1'b1;
                        state_d  = ST_WGT;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end else begin
                    drn_cnt_d = drn_cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            oc_cnt_q  <= '0;
            ic_cnt_q  <= '0;
            col_cnt_q <= '0;
            wgt_cnt_q <= '0;
            drn_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            oc_cnt_q  <= oc_cnt_d;
            ic_cnt_q  <= ic_cnt_d;
            col_cnt_q <= col_cnt_d;
            wgt_cnt_q <= wgt_cnt_d;
            drn_cnt_q <= drn_cnt_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign stride   = cfg_q.stride;
    assign wgt_read = (state_q == ST_WGT) && wgt_vld;
    assign ifm_read = (state_q == ST_IFM) && ifm_vld;

    // Output column parity equals col_cnt parity, so an odd ifm_w under stride 2
    // ends on an odd column and the last emitted strobe is the one before it.
    assign oc_col   = col_cnt_q - CNT_W'(2);
    assign last_col = (cfg_q.stride && ifm_w[0]) ? ifm_w - 1'b1 : ifm_w;
    assign emit     = ifm_read && (col_cnt_q >= CNT_W'(2)) && (!cfg_q.stride || !oc_col[0]);
    assign last_ic  = emit && (col_cnt_q == last_col) && (ic_cnt_q == ic_num);
    assign last_oc  = last_ic && (oc_cnt_q == oc_num);
    assign tag_in   = {emit, last_ic, last_oc};

    pea_33_vld_pipe #(
        .DEPTH (PE_LAT),
        .W     (3)
    ) u_vld_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        row_mask = '0;
        for (int unsigned i = 0; i < COL; i++) begin
            row_mask[i] = (ROW_W'(i) < row_vld);
        end
    end

    assign pvalid  = {COL{tag_out[2]}} & row_mask;
    assign ic_done = tag_out[1];
    assign oc_done = tag_out[0];

`ifdef PEA_33_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stalled;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stalled     = ((state_q == ST_WGT) && !wgt_vld) || ((state_q == ST_IFM) && !ifm_vld);
        if ((state_q == ST_IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (stalled && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pea_33_ctrl.sv
// Directed bench for pea_33_ctrl: cycle model feeds a scoreboard of expected psum-valid events.
module tb_pea_33_ctrl;

    localparam int unsigned COL    = 8;
    localparam int unsigned PE_LAT = 2;
    localparam int          BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       cfg_stride = 1'b0;
    logic [7:0] cfg_ic_num = '0, cfg_oc_num = '0, cfg_ifm_w = '0;
    logic [3:0] cfg_row_vld = '0;
    logic       wgt_vld = 1'b1, ifm_vld = 1'b1;
    logic       busy, done, stride, wgt_read, ifm_read, ic_done, oc_done;
    logic [7:0] pvalid;
`ifdef PEA_33_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pea_33_ctrl #(
        .COL    (COL),
        .PE_LAT (PE_LAT),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .cfg_stride  (cfg_stride),
        .cfg_ic_num  (cfg_ic_num),
        .cfg_oc_num  (cfg_oc_num),
        .cfg_ifm_w   (cfg_ifm_w),
        .cfg_row_vld (cfg_row_vld),
        .wgt_vld     (wgt_vld),
        .ifm_vld     (ifm_vld),
        .busy        (busy),
        .done        (done),
        .stride      (stride),
        .wgt_read    (wgt_read),
        .ifm_read    (ifm_read),
        .pvalid      (pvalid),
        .ic_done     (ic_done),
        .oc_done     (oc_done)
`ifdef PEA_33_CTRL_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    typedef struct {
        int         cyc;
        logic [7:0] pv;
        logic       ic;
        logic       oc;
    } exp_t;

    exp_t sbq[$];

    // Reference model: phase 0 idle, 1 wgt, 2 ifm, 3 drain, 4 done.
    int   mph = 0, mw = 0, mc = 0, md = 0, mic = 0, moc = 0, mstall = 0, cyc = 0;
    logic ms = 1'b0;
    int   micn = 0, mocn = 0, mwid = 0, mrv = 0, mlast = 0;
    bit   stall_en = 1'b0;

    int n_wgt, n_ifm, n_pv, n_ic, n_oc, n_done;
    int ifm3_cyc, pv1_cyc, ocd_cyc, done_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rowmask(input int rv);
        logic [8:0] t;
        t = (9'd1 << rv) - 9'd1;
        return t[7:0];
    endfunction

    task automatic clear_stats();
        n_wgt = 0; n_ifm = 0; n_pv = 0; n_ic = 0; n_oc = 0; n_done = 0;
        ifm3_cyc = -1; pv1_cyc = -1; ocd_cyc = -1; done_cyc = -1;
    endtask

    always @(posedge clk) begin
        #1;
        if (stall_en) begin
            wgt_vld = ($urandom_range(0, 3) != 0);
            ifm_vld = ($urandom_range(0, 3) != 0);
        end else begin
            wgt_vld = 1'b1;
            ifm_vld = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   oc_col;
        if (!rstn) begin
            mph = 0; mw = 0; mc = 0; md = 0; mic = 0; moc = 0; mstall = 0;
            sbq.delete();
        end else begin
            e.cyc = -1; e.pv = '0; e.ic = 1'b0; e.oc = 1'b0;
            if (sbq.size() > 0 && sbq[0].cyc == cyc) e = sbq.pop_front();
            chk("wgt_read", wgt_read, (mph == 1) && wgt_vld);
            chk("ifm_read", ifm_read, (mph == 2) && ifm_vld);
            chk("busy", busy, mph != 0);
            chk("done", done, mph == 4);
            chk("pvalid", pvalid, e.pv);
            chk("ic_done", ic_done, e.ic);
            chk("oc_done", oc_done, e.oc);

            if (wgt_read) n_wgt++;
            if (ifm_read) begin n_ifm++; if (n_ifm == 3) ifm3_cyc = cyc; end
            if (pvalid != 0) begin n_pv++; if (n_pv == 1) pv1_cyc = cyc; end
            if (ic_done) n_ic++;
            if (oc_done) begin n_oc++; ocd_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end

            case (mph)
                0: if (start) begin
                    ms = cfg_stride; micn = cfg_ic_num; mocn = cfg_oc_num;
                    mwid = cfg_ifm_w; mrv = cfg_row_vld;
                    mlast = ms ? ((mwid - 2) / 2) * 2 : mwid - 2;
                    mic = 0; moc = 0; mw = 0; mstall = 0; mph = 1;
                end
                1: if (!wgt_vld) mstall++;
                   else if (mw == 2) begin mw = 0; mc = 0; mph = 2; end
                   else mw++;
                2: if (!ifm_vld) mstall++;
                   else begin
                       if (mc >= 2) begin
                           oc_col = mc - 2;
                           if (!ms || (oc_col % 2) == 0) begin
                               e.cyc = cyc + PE_LAT;
                               e.pv  = rowmask(mrv);
                               e.ic  = (oc_col == mlast) && (mic == micn);
                               e.oc  = e.ic && (moc == mocn);
                               sbq.push_back(e);
                           end
                       end
                       if (mc == mwid) begin md = 0; mph = 3; end
                       else mc++;
                   end
                3: if (md == PE_LAT - 1) begin
                       md = 0;
                       if (mic < micn) begin mic++; mph = 1; end
                       else if (moc < mocn) begin mic = 0; moc++; mph = 1; end
                       else mph = 4;
                   end else md++;
                default: mph = 0;
            endcase
        end
        cyc++;
    end

    task automatic run_tile(input string name, input logic s, input int icn, input int ocn,
                            input int w, input int rv, input bit stl, input bit extra_start);
        int budget, passes, emitted;
        clear_stats();
        @(posedge clk); #2;
        cfg_stride = s; cfg_ic_num = 8'(icn); cfg_oc_num = 8'(ocn);
        cfg_ifm_w = 8'(w); cfg_row_vld = 4'(rv); start = 1'b1;
        stall_en = stl;
        @(posedge clk); #2;
        start = 1'b0;
        // Scramble cfg inputs; the tile must run on the latched copy.
        cfg_stride = ~s; cfg_ic_num = 8'd5; cfg_oc_num = 8'd5; cfg_ifm_w = 8'd3; cfg_row_vld = 4'd1;
        budget = 0;
        while (n_done == 0 && budget < BUDGET) begin
            @(posedge clk); #2;
            budget++;
            start = (extra_start && budget == 6);
        end
        start = 1'b0;
        stall_en = 1'b0;
        chk({name, ".timeout"}, budget < BUDGET, 1);
        repeat (4) @(posedge clk);
        #2;
        passes  = (icn + 1) * (ocn + 1);
        emitted = s ? ((w - 2) / 2 + 1) : (w - 1);
        chk({name, ".n_wgt"}, n_wgt, 3 * passes);
        chk({name, ".n_ifm"}, n_ifm, (w + 1) * passes);
        chk({name, ".n_pv"}, n_pv, (rv == 0) ? 0 : emitted * passes);
        chk({name, ".n_ic"}, n_ic, ocn + 1);
        chk({name, ".n_oc"}, n_oc, 1);
        chk({name, ".n_done"}, n_done, 1);
        chk({name, ".sb_empty"}, sbq.size(), 0);
        chk({name, ".stride"}, stride, s);
        chk({name, ".idle"}, busy, 0);
`ifdef PEA_33_CTRL_PERF_EN
        chk({name, ".stall_cnt"}, stall_cnt, mstall);
`endif
    endtask

    initial begin
        int budget;
        clear_stats();
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.stride", stride, 0);
        chk("rst.wgt_read", wgt_read, 0);
        chk("rst.ifm_read", ifm_read, 0);
        chk("rst.pvalid", pvalid, 0);
        chk("rst.ic_done", ic_done, 0);
        chk("rst.oc_done", oc_done, 0);
        #11 rstn = 1'b1;

        run_tile("t1", 1'b0, 0, 0, 9, 8, 1'b0, 1'b0);
        chk("t1.first_pv_lat", pv1_cyc - ifm3_cyc, PE_LAT);
        chk("t1.done_after_ocd", done_cyc - ocd_cyc, 1);
        run_tile("t2", 1'b1, 0, 0, 10, 8, 1'b0, 1'b0);
        run_tile("t2odd", 1'b1, 0, 1, 9, 8, 1'b0, 1'b0);
        run_tile("t3", 1'b0, 2, 1, 4, 8, 1'b0, 1'b0);
        run_tile("t4", 1'b0, 0, 0, 5, 3, 1'b0, 1'b0);
        run_tile("t5a", 1'b0, 2, 1, 6, 8, 1'b1, 1'b0);
        run_tile("t5b", 1'b1, 1, 0, 9, 5, 1'b1, 1'b0);
        run_tile("w2", 1'b0, 0, 0, 2, 8, 1'b0, 1'b0);
        run_tile("rv0", 1'b0, 0, 1, 4, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an IFM pass.
        clear_stats();
        @(posedge clk); #2;
        cfg_stride = 1'b1; cfg_ic_num = 8'd1; cfg_oc_num = 8'd0; cfg_ifm_w = 8'd12; cfg_row_vld = 4'd8;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        budget = 0;
        while (n_ifm < 4 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("t6.reach_ifm", budget < 200, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6.busy", busy, 0);
        chk("t6.ifm_read", ifm_read, 0);
        chk("t6.wgt_read", wgt_read, 0);
        chk("t6.pvalid", pvalid, 0);
        chk("t6.ic_done", ic_done, 0);
        chk("t6.oc_done", oc_done, 0);
        chk("t6.done", done, 0);
        chk("t6.stride", stride, 0);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6.no_done", n_done, 0);
        run_tile("t6b", 1'b0, 1, 1, 7, 6, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
